// File: rtl/conv_layer_tiled_pkg.sv
// Shared types and arithmetic helpers for the tiled convolution engine.
// Geometry is derived from the engine's own parameters through these helpers.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_ROUND,
    S_EMIT,
    S_FINISH
  } state_t;

  function automatic int out_dim(input int n, input int f);
    return n - f + 1;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int acc_width(input int dw, input int taps);
    return 2 * dw + $clog2(taps) + 1;
  endfunction

  // Round half-up, arithmetic shift by frac, saturate to dw bits, optional ReLU.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac, input int dw,
                                                   input logic relu);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (frac > 0) r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/conv_layer_tiled_if.sv
// Output tile stream of the convolution engine: data, lane mask, position,
// last flag and valid/ready handshake.
interface conv_layer_tiled_if #(
  parameter int P          = 14,
  parameter int DATA_WIDTH = 16,
  parameter int ROW_W      = 5,
  parameter int COL_W      = 5
);
  logic [P*DATA_WIDTH-1:0] out_data;
  logic [P-1:0]            out_mask;
  logic [ROW_W-1:0]        out_row;
  logic [COL_W-1:0]        out_col;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport master (output out_data, out_mask, out_row, out_col, out_valid, out_last,
                  input  out_ready);
  modport slave  (input  out_data, out_mask, out_row, out_col, out_valid, out_last,
                  output out_ready);
endinterface

// File: rtl/conv_layer_tiled_mac_lane.sv
// One MAC lane: signed multiply-accumulate with synchronous clear.
// The accumulator is pure datapath and is always cleared before use.
module conv_mac_lane #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 38
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] coeff,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;

  assign prod = sample * coeff;

  always_ff @(posedge clk) begin
    if (clear)       acc <= '0;
    else if (enable) acc <= acc + ACC_W'(prod);
  end
endmodule

// File: rtl/conv_layer_tiled.sv
// Tiled valid-mode multi-channel 2-D convolution: P lanes compute up to P
// adjacent output pixels per tile, streamed out over a valid/ready handshake.
module conv_layer_tiled
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = 8,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int P          = 14
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          relu_en,
  input  logic [D*H*W*DATA_WIDTH-1:0]   image,
  input  logic [D*F*F*DATA_WIDTH-1:0]   filter,
  conv_layer_tiled_if.master            out_if,
  output logic                          busy,
  output logic                          done
);
  localparam int OH    = out_dim(H, F);
  localparam int OW    = out_dim(W, F);
  localparam int ACC_W = acc_width(DATA_WIDTH, D * F * F);
  localparam int RW    = $clog2(OH) + 1;
  localparam int CW    = $clog2(OW) + 1;
  localparam int NI    = D * H * W;
  localparam int NF    = D * F * F;
  localparam int XW    = $clog2(D + F) + 1;
  localparam logic [XW-1:0] D_LAST = XW'(D - 1);
  localparam logic [XW-1:0] F_LAST = XW'(F - 1);

  state_t                        state;
  logic [RW-1:0]                 row;
  logic [CW-1:0]                 col;
  logic [XW-1:0]                 td, ti, tj;
  logic                          relu_q;
  logic signed [DATA_WIDTH-1:0]  coeff;
  logic [P-1:0]                  lane_mask;
  logic signed [ACC_W-1:0]       acc [P];
  logic                          tile_last;

  assign tile_last = (int'(row) == OH - 1) && (int'(col) + P >= OW);

  always_comb begin
    int fi;
    fi    = int'(td) * F * F + int'(ti) * F + int'(tj);
    coeff = filter[(NF-1-fi)*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar k = 0; k < P; k++) begin : g_lane
    logic                         on;
    logic signed [DATA_WIDTH-1:0] smp;

    // Lanes past the right edge of the output row never accumulate.
    always_comb begin
      int e;
      on  = (int'(col) + k) < OW;
      e   = int'(td) * H * W + (int'(row) + int'(ti)) * W + int'(col) + k + int'(tj);
      smp = '0;
      if (on) smp = image[(NI-1-e)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign lane_mask[P-1-k] = on;

    conv_mac_lane #(.DATA_W(DATA_WIDTH), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .clear  (state == S_CLEAR),
      .enable ((state == S_MAC) && on),
      .sample (smp),
      .coeff  (coeff),
      .acc    (acc[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      row              <= '0;
      col              <= '0;
      td               <= '0;
      ti               <= '0;
      tj               <= '0;
      relu_q           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_mask  <= '0;
      out_if.out_row   <= '0;
      out_if.out_col   <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            relu_q <= relu_en;
            row    <= '0;
            col    <= '0;
            busy   <= 1'b1;
            state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          td    <= '0;
          ti    <= '0;
          tj    <= '0;
          state <= S_MAC;
        end
        // Tap order: channel outermost, then filter row, then filter column.
        S_MAC: begin
          if (tj != F_LAST) tj <= tj + 1'b1;
          else begin
            tj <= '0;
            if (ti != F_LAST) ti <= ti + 1'b1;
            else begin
              ti <= '0;
              if (td != D_LAST) td <= td + 1'b1;
              else begin
                td    <= '0;
                state <= S_ROUND;
              end
            end
          end
        end
        S_ROUND: begin
          for (int k = 0; k < P; k++) begin
            out_if.out_data[(P-1-k)*DATA_WIDTH +: DATA_WIDTH] <= lane_mask[P-1-k] ?
              DATA_WIDTH'(round_sat(64'(acc[k]), FRAC, DATA_WIDTH, relu_q)) : '0;
          end
          out_if.out_mask  <= lane_mask;
          out_if.out_row   <= row;
          out_if.out_col   <= col;
          out_if.out_last  <= tile_last;
          out_if.out_valid <= 1'b1;
          state            <= S_EMIT;
        end
        S_EMIT: begin
          if (out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
            out_if.out_last  <= 1'b0;
            if (out_if.out_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              if (int'(col) + P >= OW) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + CW'(P);
              end
              state <= S_CLEAR;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_layer_tiled.sv
// Bench for conv_layer_tiled: two engine instances (D=1/P=4 and D=2/P=3 on a
// 6x6 image with a 3x3 filter) checked against a reference scoreboard.
module tb_conv_layer_tiled;
  localparam int DW = 16;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  mask;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last;
  } tile_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic relu_en = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic ready = 1'b1;
  logic [1*36*DW-1:0] image_a = '0;
  logic [2*36*DW-1:0] image_b = '0;
  logic [1*9*DW-1:0]  filter_a = '0;
  logic [2*9*DW-1:0]  filter_b = '0;
  logic busy_a, done_a, busy_b, done_b;

  logic signed [15:0] img [2][6][6];
  logic signed [15:0] flt [2][3][3];
  tile_t q[$];
  int    sel = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  logic [63:0] first_data;
  logic [3:0]  edge_mask;

  logic [63:0] o_data;
  logic [3:0]  o_mask;
  logic [2:0]  o_row, o_col;
  logic        o_valid, o_last, o_busy, o_done;

  conv_layer_tiled_if #(.P(4), .DATA_WIDTH(DW), .ROW_W(3), .COL_W(3)) if_a ();
  conv_layer_tiled_if #(.P(3), .DATA_WIDTH(DW), .ROW_W(3), .COL_W(3)) if_b ();
  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;

  conv_layer_tiled #(.DATA_WIDTH(DW), .FRAC(8), .D(1), .H(6), .W(6), .F(3), .P(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .relu_en(relu_en),
    .image(image_a), .filter(filter_a), .out_if(if_a), .busy(busy_a), .done(done_a));
  conv_layer_tiled #(.DATA_WIDTH(DW), .FRAC(8), .D(2), .H(6), .W(6), .F(3), .P(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .relu_en(relu_en),
    .image(image_b), .filter(filter_b), .out_if(if_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  always_comb begin
    if (sel == 0) begin
      o_data = if_a.out_data;  o_mask = if_a.out_mask;
      o_row  = if_a.out_row;   o_col  = if_a.out_col;
      o_valid = if_a.out_valid; o_last = if_a.out_last;
      o_busy = busy_a;         o_done = done_a;
    end else begin
      o_data = {16'h0, if_b.out_data}; o_mask = {1'b0, if_b.out_mask};
      o_row  = if_b.out_row;   o_col  = if_b.out_col;
      o_valid = if_b.out_valid; o_last = if_b.out_last;
      o_busy = busy_b;         o_done = done_b;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pack_inputs();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 6; c++) begin
          int e;
          e = d * 36 + r * 6 + c;
          image_b[(71-e)*16 +: 16] = img[d][r][c];
          if (d == 0) image_a[(35-e)*16 +: 16] = img[0][r][c];
        end
      end
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          int e;
          e = d * 9 + i * 3 + j;
          filter_b[(17-e)*16 +: 16] = flt[d][i][j];
          if (d == 0) filter_a[(8-e)*16 +: 16] = flt[0][i][j];
        end
      end
    end
  endtask

  task automatic fill(input logic signed [15:0] iv, input logic signed [15:0] fv, input bit rnd);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          img[d][r][c] = rnd ? 16'($urandom_range(0, 1023)) - 16'd512 : iv;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          flt[d][i][j] = rnd ? 16'($urandom_range(0, 1023)) - 16'd512 : fv;
    end
    pack_inputs();
  endtask

  // Reference: direct convolution sums, rounded and saturated to Q8.8.
  task automatic push_expected(input int dd, input int pp, input logic relu);
    tile_t  t;
    longint acc, v;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c += pp) begin
        t = '0;
        t.row = 3'(r);
        t.col = 3'(c);
        t.last = (r == 3) && (c + pp >= 4);
        for (int k = 0; k < pp; k++) begin
          if (c + k < 4) begin
            acc = 0;
            for (int d = 0; d < dd; d++)
              for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                  acc += longint'(img[d][r+i][c+k+j]) * longint'(flt[d][i][j]);
            v = (acc + 128) >>> 8;
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            if (relu && v < 0) v = 0;
            t.data[(pp-1-k)*16 +: 16] = v[15:0];
            t.mask[pp-1-k] = 1'b1;
          end
        end
        q.push_back(t);
      end
    end
  endtask

  task automatic drive_start(input int s, input logic v);
    if (s == 0) start_a = v;
    else start_b = v;
  endtask

  task automatic run_layer(input int s, input logic relu, input bit bp, input int abort_cyc,
                           input bit extra_start, input int exp_first);
    tile_t t, held;
    bit    hold;
    int    cyc, first, n_done, exp_done;
    sel = s;
    relu_en = relu;
    ready = 1'b1;
    push_expected(s == 0 ? 1 : 2, s == 0 ? 4 : 3, relu);
    @(posedge clk); #1;
    drive_start(s, 1'b1);
    @(posedge clk); #1;
    drive_start(s, 1'b0);
    relu_en = ~relu;
    cyc = 0; first = -1; n_done = 0; exp_done = -1; hold = 0;
    while (cyc < 3000) begin
      if (cyc == abort_cyc) begin
        reset_n = 1'b0;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_mask", o_mask, 0);
        check("rst_rowcol", {o_row, o_col}, 0);
        check("rst_busy_done_last", {o_busy, o_done, o_last}, 0);
        q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        return;
      end
      if (cyc == 1) check("busy_after_start", o_busy, 1);
      if (o_valid && first < 0) begin
        first = cyc;
        if (exp_first > 0) check("first_valid_latency", cyc, exp_first);
      end
      if (hold) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, held.data);
        check("hold_pos", {o_mask, o_row, o_col, o_last}, {held.mask, held.row, held.col, held.last});
      end
      ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      hold = 0;
      if (o_valid) begin
        if (ready) begin
          check("tile_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            t = q.pop_front();
            if (t.row == 0 && t.col == 0) first_data = o_data;
            if (t.row == 0 && t.col == 3) edge_mask = o_mask;
            check("tile_data", o_data, t.data);
            check("tile_mask", o_mask, t.mask);
            check("tile_row", o_row, t.row);
            check("tile_col", o_col, t.col);
            check("tile_last", o_last, t.last);
            if (q.size() == 0) exp_done = cyc + 1;
          end
        end else begin
          hold = 1;
          held.data = o_data; held.mask = o_mask; held.row = o_row;
          held.col = o_col;   held.last = o_last;
        end
      end
      if (o_done) begin
        n_done++;
        check("done_timing", cyc, exp_done);
        check("busy_low_at_done", o_busy, 0);
      end
      drive_start(s, extra_start && (cyc == 20 || o_done));
      if (n_done > 0 && cyc >= exp_done + 6) break;
      @(posedge clk); #1;
      cyc++;
    end
    drive_start(s, 1'b0);
    ready = 1'b1;
    check("done_count", n_done, 1);
    check("queue_drained", q.size(), 0);
    check("idle_after_layer", {o_busy, o_valid}, 0);
  endtask

  initial begin
    int nd;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sel = 0;
    check("reset_valid_a", o_valid, 0);
    check("reset_last_a", o_last, 0);
    check("reset_busy_done_a", {o_busy, o_done}, 0);
    check("reset_data_a", o_data, 0);
    check("reset_mask_a", o_mask, 0);
    check("reset_rowcol_a", {o_row, o_col}, 0);
    sel = 1;
    #1;
    check("reset_valid_b", o_valid, 0);
    check("reset_data_b", o_data, 0);
    check("reset_busy_b", o_busy, 0);
    reset_n = 1'b1;

    fill(16'sh0100, 16'sh0100, 0);
    run_layer(0, 1'b0, 0, -1, 0, 11);
    check("ones_tile0", first_data, {4{16'h0900}});

    fill(16'sh0, 16'sh0, 1);
    run_layer(1, 1'b0, 0, -1, 0, 20);
    check("b_edge_mask", edge_mask, 4'b0100);
    run_layer(1, 1'b0, 1, -1, 0, 20);

    fill(16'sh7F00, 16'sh7F00, 0);
    run_layer(0, 1'b0, 0, -1, 0, 11);
    check("sat_pos", first_data, {4{16'h7FFF}});
    fill(16'sh7F00, -16'sh7F00, 0);
    run_layer(0, 1'b1, 0, -1, 0, 11);
    check("sat_relu", first_data, {4{16'h0000}});
    run_layer(0, 1'b0, 0, -1, 0, 11);
    check("sat_neg", first_data, {4{16'h8000}});

    fill(16'sh0, 16'sh0, 1);
    run_layer(0, 1'b0, 0, 16, 0, -1);
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_done || o_valid) nd++;
    end
    check("no_done_after_abort", nd, 0);
    run_layer(0, 1'b0, 0, -1, 0, 11);
    run_layer(0, 1'b0, 1, -1, 1, 11);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
